axis_deadlock_monitor_n: RTL and testbench
==========================================

// Module: axis_deadlock_monitor_n
// PURPOSE
//   Synthesizable, parametrised kernel deadlock monitor for N AXI-Stream ports and M sub-instances.
//   Decides that the kernel is stalled, confirms the stall over a programmable window and latches it.
//   Captures a diagnosis snapshot of which ports are externally blocked and which are unreached.
//   Sits beside the kernel top, fed by per-port TDATA_blk_n (inverted) and per-instance ap_idle/block.
// PARAMETERS
//   NUM_AXIS      2   number of monitored axis ports (>=1)
//   NUM_INST      2   number of monitored sub-instances (>=1)
//   START_DELAY   10  cycles after reset release before monitoring is armed (>=1)
//   STABLE_CYCLES 2   consecutive raw-block cycles required to declare deadlock (>=1)
//   CNT_W         16  width of the optional block-cycle counter
// PORTS
//   kernel_monitor_clock  in   1            sole clock, rising edge
//   kernel_monitor_reset  in   1            synchronous, active-high reset
//   axis_block_sigs       in   NUM_AXIS     1 = port blocked by its outer side (~TDATA_blk_n)
//   inst_idle_sigs        in   NUM_INST     1 = instance idle
//   inst_block_sigs       in   NUM_INST     1 = instance blocked internally
//   clear                 in   1            1-cycle pulse: leave LOCKED, drop snapshots, re-arm
//   block                 out  1            registered raw block condition
//   deadlock              out  1            sticky: confirmed deadlock
//   blocked_axis          out  NUM_AXIS     snapshot of axis_block_sigs at lock entry
//   unreached_axis        out  NUM_AXIS     snapshot of ~axis_block_sigs at lock entry
//   first_axis_idx        out  $clog2(NUM_AXIS)+1  lowest set index in blocked_axis; 0 when none valid
//   first_axis_vld        out  1            1 = first_axis_idx is meaningful
//   block_cycles          out  CNT_W        total raw-block cycles (see CONFIGURATION)
// BEHAVIOUR
//   Reset: all outputs 0; FSM = ARM; delay and confirm counters = 0.
//   raw = (|axis_block_sigs | |inst_block_sigs) & ( |axis_block_sigs | &(inst_idle_sigs|inst_block_sigs) ).
//   block <= raw every cycle in every state except ARM (forced 0 in ARM); latency 1 cycle.
//   FSM:
//     ARM     : count START_DELAY cycles; at count==START_DELAY-1 -> WATCH. raw ignored.
//     WATCH   : raw=1 -> CONFIRM with confirm_cnt=1; else stay.
//     CONFIRM : raw=1 -> confirm_cnt++; when confirm_cnt reaches STABLE_CYCLES -> LOCKED.
//               raw=0 -> WATCH, confirm_cnt=0 (window is strictly consecutive).
//               STABLE_CYCLES=1: WATCH goes straight to LOCKED on first raw cycle.
//     LOCKED  : on entry cycle register deadlock=1, blocked_axis, unreached_axis, first_axis_idx/vld
//               from that cycle's inputs; all held regardless of inputs until clear/reset.
//   first_axis_vld=0 when lock was entered with axis_block_sigs==0 (instance-only stall).
//   clear in LOCKED: next cycle deadlock=0, snapshots=0, FSM -> WATCH (no re-run of START_DELAY).
//   clear in ARM/WATCH/CONFIRM: confirm_cnt=0, FSM unchanged except CONFIRM -> WATCH.
//   clear and raw same cycle: clear wins; raw is re-evaluated from the following cycle.
//   Reset asserted mid-CONFIRM or in LOCKED: everything returns to reset values next edge.
//   Counter widths sized with $clog2; no wrap in delay/confirm counters (they stop at target).
// CONFIGURATION
//   DLMON_BLOCK_CNT_EN defined: block_cycles increments on every cycle block is set, saturating at
//     all-ones; cleared by reset or clear; continues counting in LOCKED.
//   Undefined: block_cycles tied to 0, counter logic absent; all other behaviour identical.
// TESTING  (NUM_AXIS=2, NUM_INST=2, START_DELAY=10, STABLE_CYCLES=2 unless noted)
//   1 axis=2'b11 from cycle 0 after reset -> block=0, deadlock=0 through cycle 10; deadlock=1 by 13.
//   2 axis=2'b01 for 1 cycle, 0 for 1, 2'b01 for 1 -> deadlock stays 0 (window broken).
//   3 axis=2'b10 held 2 cycles -> deadlock=1, blocked_axis=10, unreached_axis=01, first_axis_idx=1.
//   4 axis=0, inst_block=2'b01, inst_idle=2'b10 held -> deadlock=1, first_axis_vld=0; change
//     inputs -> snapshots unchanged; clear -> deadlock=0 next cycle, relock after 2 raw cycles.
//   5 reset pulsed while in CONFIRM -> all outputs 0, 10-cycle arm delay re-applies.
//   6 with DLMON_BLOCK_CNT_EN, CNT_W=4: block held 20 cycles -> block_cycles saturates at 15.

Source files
------------

// File: rtl/axis_deadlock_monitor_n.sv
// axis_deadlock_monitor_n: confirms and latches a kernel stall across NUM_AXIS stream ports and NUM_INST sub-instances
// Ports: kernel_monitor_clock/kernel_monitor_reset (sync, active-high); axis_block_sigs, inst_idle_sigs,
//   inst_block_sigs, clear in; block, deadlock, blocked_axis, unreached_axis, first_axis_idx,
//   first_axis_vld, block_cycles out. DLMON_BLOCK_CNT_EN enables the saturating block_cycles counter.
module axis_deadlock_monitor_n #(
   parameter int NUM_AXIS      = 2,
   parameter int NUM_INST      = 2,
   parameter int START_DELAY   = 10,
   parameter int STABLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic                          kernel_monitor_clock,
   input  logic                          kernel_monitor_reset,
   input  logic [NUM_AXIS-1:0]           axis_block_sigs,
   input  logic [NUM_INST-1:0]           inst_idle_sigs,
   input  logic [NUM_INST-1:0]           inst_block_sigs,
   input  logic                          clear,
   output logic                          block,
   output logic                          deadlock,
   output logic [NUM_AXIS-1:0]           blocked_axis,
   output logic [NUM_AXIS-1:0]           unreached_axis,
   output logic [$clog2(NUM_AXIS):0]     first_axis_idx,
   output logic                          first_axis_vld,
   output logic [CNT_W-1:0]              block_cycles
);
   localparam int IW = $clog2(NUM_AXIS) + 1;
   localparam int DW = $clog2(START_DELAY + 1);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   typedef enum logic [1:0] {ARM, WATCH, CONFIRM, LOCKED} state_t;
   state_t state;
   logic [DW-1:0] delay_cnt;
   logic [CW-1:0] confirm_cnt;
   logic raw, lock_now, low_vld;
   logic [IW-1:0] low_idx;
   assign raw = (|axis_block_sigs | |inst_block_sigs) & (|axis_block_sigs | &(inst_idle_sigs | inst_block_sigs));
   assign lock_now = raw && !clear && ((state == WATCH && STABLE_CYCLES == 1) ||
                     (state == CONFIRM && confirm_cnt == CW'(STABLE_CYCLES - 1)));
   always_comb begin
      low_idx = '0;
      low_vld = 1'b0;
      for (int i = NUM_AXIS - 1; i >= 0; i--) begin
         low_idx = axis_block_sigs[i] ? IW'(i) : low_idx;
         low_vld = low_vld | axis_block_sigs[i];
      end
   end
   always_ff @(posedge kernel_monitor_clock) begin
      if (kernel_monitor_reset) begin
         state          <= ARM;
         delay_cnt      <= '0;
         confirm_cnt    <= '0;
         block          <= 1'b0;
         deadlock       <= 1'b0;
         blocked_axis   <= '0;
         unreached_axis <= '0;
         first_axis_idx <= '0;
         first_axis_vld <= 1'b0;
      end else begin
         block <= (state != ARM) && raw;
         if (lock_now) begin
            state          <= LOCKED;
            confirm_cnt    <= CW'(STABLE_CYCLES);
            deadlock       <= 1'b1;
            blocked_axis   <= axis_block_sigs;
            unreached_axis <= ~axis_block_sigs;
            first_axis_idx <= low_idx;
            first_axis_vld <= low_vld;
         end else begin
            case (state)
               ARM: begin
                  confirm_cnt <= '0;
                  if (delay_cnt == DW'(START_DELAY - 1)) state <= WATCH;
                  else delay_cnt <= delay_cnt + DW'(1);
               end
               WATCH: begin
                  state       <= (raw && !clear) ? CONFIRM : WATCH;
                  confirm_cnt <= (raw && !clear) ? CW'(1) : '0;
               end
               CONFIRM: begin
                  state       <= (raw && !clear) ? CONFIRM : WATCH;
                  confirm_cnt <= (raw && !clear) ? confirm_cnt + CW'(1) : '0;
               end
               default: if (clear) begin
                  state          <= WATCH;
                  confirm_cnt    <= '0;
                  deadlock       <= 1'b0;
                  blocked_axis   <= '0;
                  unreached_axis <= '0;
                  first_axis_idx <= '0;
                  first_axis_vld <= 1'b0;
               end
            endcase
         end
      end
   end
`ifdef DLMON_BLOCK_CNT_EN
   always_ff @(posedge kernel_monitor_clock) begin
      if (kernel_monitor_reset || clear) block_cycles <= '0;
      else if (block && !(&block_cycles)) block_cycles <= block_cycles + CNT_W'(1);
   end
`else
   assign block_cycles = '0;
`endif
endmodule

// File: tb/tb_axis_deadlock_monitor_n.sv
// tb_axis_deadlock_monitor_n: randomized and directed checks of axis_deadlock_monitor_n against a behavioural model
module tb_axis_deadlock_monitor_n;
   logic kernel_monitor_clock = 1'b0;
   logic kernel_monitor_reset = 1'b1;
   logic [1:0] axis_block_sigs = '0;
   logic [1:0] inst_idle_sigs = '0;
   logic [1:0] inst_block_sigs = '0;
   logic clear = 1'b0;
   logic block, deadlock, first_axis_vld;
   logic [1:0] blocked_axis, unreached_axis, first_axis_idx;
   logic [3:0] block_cycles;
   int vectors = 0;
   int miscompares = 0;
   int m_since, m_run;
   logic m_lock, m_vld, m_block;
   logic [1:0] m_blocked, m_unr, m_idx;
   logic [3:0] m_bc;
   axis_deadlock_monitor_n #(.NUM_AXIS(2), .NUM_INST(2), .START_DELAY(10), .STABLE_CYCLES(2), .CNT_W(4)) dut (
      .kernel_monitor_clock(kernel_monitor_clock),
      .kernel_monitor_reset(kernel_monitor_reset),
      .axis_block_sigs(axis_block_sigs),
      .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs),
      .clear(clear),
      .block(block),
      .deadlock(deadlock),
      .blocked_axis(blocked_axis),
      .unreached_axis(unreached_axis),
      .first_axis_idx(first_axis_idx),
      .first_axis_vld(first_axis_vld),
      .block_cycles(block_cycles)
   );
   always #5 kernel_monitor_clock = ~kernel_monitor_clock;
   task automatic step(input logic [1:0] a, input logic [1:0] ii, input logic [1:0] ib, input logic c);
      logic raw;
      logic armed;
      axis_block_sigs = a;
      inst_idle_sigs = ii;
      inst_block_sigs = ib;
      clear = c;
      @(posedge kernel_monitor_clock);
      raw = (a != 0 || ib != 0) && (a != 0 || (ii | ib) == 2'b11);
      if (kernel_monitor_reset) begin
         m_since = 0; m_run = 0; m_lock = 0; m_vld = 0; m_block = 0;
         m_blocked = 0; m_unr = 0; m_idx = 0; m_bc = 0;
      end else begin
`ifdef DLMON_BLOCK_CNT_EN
         if (c) m_bc = 0;
         else if (m_block && m_bc != 4'd15) m_bc = m_bc + 4'd1;
`else
         m_bc = 0;
`endif
         armed = m_since >= 10;
         if (m_lock) begin
            if (c) begin
               m_lock = 0; m_blocked = 0; m_unr = 0; m_idx = 0; m_vld = 0; m_run = 0;
            end
         end else if (armed) begin
            if (c || !raw) m_run = 0;
            else begin
               m_run++;
               if (m_run == 2) begin
                  m_lock = 1; m_blocked = a; m_unr = ~a; m_vld = (a != 0);
                  m_idx = a[0] ? 2'd0 : a[1] ? 2'd1 : 2'd0;
                  m_run = 0;
               end
            end
         end
         m_block = armed && raw;
         if (m_since < 1000) m_since++;
      end
      #1;
      clear = 1'b0;
   endtask
   task automatic arm_up();
      kernel_monitor_reset = 1'b1;
      step(0, 0, 0, 0);
      kernel_monitor_reset = 1'b0;
      repeat (10) step(0, 0, 0, 0);
   endtask
   task automatic test_reset();
      kernel_monitor_reset = 1'b1;
      repeat (3) step(2'b11, 2'b11, 2'b11, 0);
      vectors++;
      if ({block, deadlock, first_axis_vld} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 000", {block, deadlock, first_axis_vld});
      end
      vectors++;
      if ({blocked_axis, unreached_axis, first_axis_idx} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_snap: got %b expected 000000", {blocked_axis, unreached_axis, first_axis_idx});
      end
      vectors++;
      if (block_cycles !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_cnt: got %0d expected 0", block_cycles);
      end
      kernel_monitor_reset = 1'b0;
   endtask
   task automatic test_arm_delay();
      kernel_monitor_reset = 1'b1;
      step(0, 0, 0, 0);
      kernel_monitor_reset = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step(2'b11, 0, 0, 0);
         if (k <= 10) begin
            vectors++;
            if ({block, deadlock} !== 2'b00) begin
               miscompares++;
               $display("FAIL arm_quiet cycle %0d: got %b expected 00", k, {block, deadlock});
            end
         end
         vectors++;
         if ({block, deadlock} !== {m_block, m_lock}) begin
            miscompares++;
            $display("FAIL arm_model cycle %0d: got %b expected %b", k, {block, deadlock}, {m_block, m_lock});
         end
      end
      vectors++;
      if (deadlock !== 1'b1) begin
         miscompares++;
         $display("FAIL arm_lock: got %b expected 1", deadlock);
      end
   endtask
   task automatic test_window();
      logic [1:0] pat [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
      arm_up();
      for (int k = 0; k < 4; k++) begin
         step(pat[k], 0, 0, 0);
         vectors++;
         if (deadlock !== 1'b0 || m_lock !== 1'b0) begin
            miscompares++;
            $display("FAIL window %0d: got %b expected 0", k, deadlock);
         end
      end
   endtask
   task automatic test_snapshot();
      step(2'b10, 0, 0, 0);
      vectors++;
      if (deadlock !== 1'b0) begin
         miscompares++;
         $display("FAIL snap_early: got %b expected 0", deadlock);
      end
      step(2'b10, 0, 0, 0);
      vectors++;
      if ({deadlock, blocked_axis, unreached_axis, first_axis_idx, first_axis_vld} !== 8'b1_10_01_01_1) begin
         miscompares++;
         $display("FAIL snap_lock: got %b expected 11001011",
                  {deadlock, blocked_axis, unreached_axis, first_axis_idx, first_axis_vld});
      end
      repeat (4) begin
         step(2'($urandom), 2'($urandom), 2'($urandom), 0);
         vectors++;
         if ({deadlock, blocked_axis, unreached_axis, first_axis_idx, first_axis_vld} !== 8'b1_10_01_01_1) begin
            miscompares++;
            $display("FAIL snap_hold: got %b expected 11001011",
                     {deadlock, blocked_axis, unreached_axis, first_axis_idx, first_axis_vld});
         end
      end
   endtask
   task automatic test_inst_stall();
      step(0, 0, 0, 1);
      vectors++;
      if (deadlock !== 1'b0) begin
         miscompares++;
         $display("FAIL inst_clear0: got %b expected 0", deadlock);
      end
      repeat (2) step(0, 2'b10, 2'b01, 0);
      vectors++;
      if ({deadlock, first_axis_vld, blocked_axis, unreached_axis} !== 6'b10_00_11) begin
         miscompares++;
         $display("FAIL inst_lock: got %b expected 100011", {deadlock, first_axis_vld, blocked_axis, unreached_axis});
      end
      repeat (4) begin
         step(2'($urandom), 2'($urandom), 2'($urandom), 0);
         vectors++;
         if ({deadlock, first_axis_vld, blocked_axis, unreached_axis} !== 6'b10_00_11) begin
            miscompares++;
            $display("FAIL inst_hold: got %b expected 100011", {deadlock, first_axis_vld, blocked_axis, unreached_axis});
         end
      end
      step(0, 2'b10, 2'b01, 1);
      vectors++;
      if ({deadlock, unreached_axis} !== 3'b000) begin
         miscompares++;
         $display("FAIL inst_clear: got %b expected 000", {deadlock, unreached_axis});
      end
      step(0, 2'b10, 2'b01, 0);
      vectors++;
      if (deadlock !== 1'b0) begin
         miscompares++;
         $display("FAIL inst_relock_early: got %b expected 0", deadlock);
      end
      step(0, 2'b10, 2'b01, 0);
      vectors++;
      if (deadlock !== 1'b1) begin
         miscompares++;
         $display("FAIL inst_relock: got %b expected 1", deadlock);
      end
   endtask
   task automatic test_reset_mid_confirm();
      step(0, 0, 0, 1);
      step(2'b01, 0, 0, 0);
      kernel_monitor_reset = 1'b1;
      step(2'b01, 0, 0, 0);
      kernel_monitor_reset = 1'b0;
      vectors++;
      if ({block, deadlock, blocked_axis, first_axis_vld, block_cycles} !== 9'b0) begin
         miscompares++;
         $display("FAIL midrst_zero: got %b expected 0", {block, deadlock, blocked_axis, first_axis_vld, block_cycles});
      end
      for (int k = 1; k <= 13; k++) begin
         step(2'b01, 0, 0, 0);
         if (k <= 10) begin
            vectors++;
            if ({block, deadlock} !== 2'b00) begin
               miscompares++;
               $display("FAIL midrst_arm cycle %0d: got %b expected 00", k, {block, deadlock});
            end
         end
      end
      vectors++;
      if (deadlock !== m_lock || deadlock !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_relock: got %b expected 1", deadlock);
      end
   endtask
   task automatic test_block_counter();
      arm_up();
      repeat (20) step(2'b11, 0, 0, 0);
      vectors++;
`ifdef DLMON_BLOCK_CNT_EN
      if (block_cycles !== 4'd15) begin
         miscompares++;
         $display("FAIL cnt_sat: got %0d expected 15", block_cycles);
      end
`else
      if (block_cycles !== 4'd0) begin
         miscompares++;
         $display("FAIL cnt_off: got %0d expected 0", block_cycles);
      end
`endif
      vectors++;
      if (block_cycles !== m_bc) begin
         miscompares++;
         $display("FAIL cnt_model: got %0d expected %0d", block_cycles, m_bc);
      end
   endtask
   task automatic test_random();
      logic [12:0] got, exp;
      for (int k = 0; k < 600; k++) begin
         kernel_monitor_reset = ($urandom_range(0, 99) == 0);
         step(($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00, 2'($urandom), 2'($urandom),
              $urandom_range(0, 11) == 0);
         got = {block, deadlock, blocked_axis, unreached_axis, first_axis_idx, first_axis_vld, block_cycles};
         exp = {m_block, m_lock, m_blocked, m_unr, m_idx, m_vld, m_bc};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL random step %0d: got %b expected %b", k, got, exp);
         end
      end
      kernel_monitor_reset = 1'b0;
   endtask
   initial begin
      test_reset();
      test_arm_delay();
      test_window();
      test_snapshot();
      test_inst_stall();
      test_reset_mid_confirm();
      test_block_counter();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
